// File: rtl/exception_unit_pkg.sv
// Shared CPU definitions for the exception unit, MMU and CP0: exception codes,
// Status/Cause field positions, default vector and the unit's internal enums.
package exception_unit_pkg;

   localparam int STATUS_IE_BIT  = 0;
   localparam int STATUS_EXL_BIT = 1;
   localparam int STATUS_IM_LSB  = 8;
   localparam int CAUSE_IP_LSB   = 8;
   localparam int CAUSE_EXC_LSB  = 2;

   localparam int MMU_EXC_NONE       = 0;
   localparam int CPU_EXCEPTION_INT  = 0;
   localparam int CPU_EXCEPTION_MOD  = 1;
   localparam int CPU_EXCEPTION_TLBL = 2;
   localparam int CPU_EXCEPTION_TLBS = 3;
   localparam int CPU_EXCEPTION_SYS  = 8;

   localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h8000_0180;

   typedef enum logic [1:0] {
      KIND_INT,
      KIND_MMU,
      KIND_SYS,
      KIND_ERET
   } exc_kind_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_COMMIT
   } exc_state_e;

   function automatic logic [31:0] status_with_exl(input logic [31:0] status,
                                                    input logic        exl);
      logic [31:0] result;
      result                 = status;
      result[STATUS_EXL_BIT] = exl;
      return result;
   endfunction

endpackage

// File: rtl/exception_unit_if.sv
// Pipeline/CP0 side bundle of the exception unit. The slave modport is the
// exception unit itself; the master modport is the pipeline and CP0.
interface exception_unit_if #(
   parameter int IRQ_W = 8,
   parameter int EXC_W = 5
);
   logic [EXC_W-1:0] mmu_exception;
   logic             syscall;
   logic             eret;
   logic [IRQ_W-1:0] irq;
   logic [31:0]      pc;
   logic [31:0]      bad_vaddr;
   logic [31:0]      cp0_status;
   logic [31:0]      cp0_cause;
   logic [31:0]      cp0_epc;
   logic             flush_ack;

   logic             flush_req;
   logic             busy;
   logic             redirect;
   logic [31:0]      redirect_pc;
   logic             we_status;
   logic             we_cause;
   logic             we_epc;
   logic             we_badVAddr;
   logic [31:0]      out_status;
   logic [31:0]      out_cause;
   logic [31:0]      out_epc;
   logic [31:0]      out_badVAddr;

   modport master (
      output mmu_exception, syscall, eret, irq, pc, bad_vaddr,
             cp0_status, cp0_cause, cp0_epc, flush_ack,
      input  flush_req, busy, redirect, redirect_pc,
             we_status, we_cause, we_epc, we_badVAddr,
             out_status, out_cause, out_epc, out_badVAddr
   );

   modport slave (
      input  mmu_exception, syscall, eret, irq, pc, bad_vaddr,
             cp0_status, cp0_cause, cp0_epc, flush_ack,
      output flush_req, busy, redirect, redirect_pc,
             we_status, we_cause, we_epc, we_badVAddr,
             out_status, out_cause, out_epc, out_badVAddr
   );

endinterface

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder for the exception unit:
// interrupt > MMU fault > syscall > ERET.
module exc_prio_enc
   import exception_unit_pkg::*;
#(
   parameter int IRQ_W = 8,
   parameter int EXC_W = 5
) (
   input  logic [IRQ_W-1:0] i_masked,
   input  logic             i_int_en,
   input  logic [EXC_W-1:0] i_mmu_exception,
   input  logic             i_syscall,
   input  logic             i_eret,
   output logic             o_valid,
   output exc_kind_e        o_kind,
   output logic [EXC_W-1:0] o_code
);

   always_comb begin
      o_valid = 1'b1;
      o_kind  = KIND_INT;
      o_code  = EXC_W'(CPU_EXCEPTION_INT);
      if (i_int_en && (|i_masked)) begin
         o_kind = KIND_INT;
         o_code = EXC_W'(CPU_EXCEPTION_INT);
      end else if (i_mmu_exception != EXC_W'(MMU_EXC_NONE)) begin
         o_kind = KIND_MMU;
         o_code = i_mmu_exception;
      end else if (i_syscall) begin
         o_kind = KIND_SYS;
         o_code = EXC_W'(CPU_EXCEPTION_SYS);
      end else if (i_eret) begin
         o_kind = KIND_ERET;
         o_code = EXC_W'(CPU_EXCEPTION_INT);
      end else begin
         o_valid = 1'b0;
      end
   end

endmodule

// File: rtl/exception_unit.sv
// Sequential exception unit: IDLE -> FLUSH -> COMMIT with registered CP0 writes
// and PC redirect. Define EXCEPTION_UNIT_IRQ_EDGE_EN for edge-captured IRQs.
module exception_unit
   import exception_unit_pkg::*;
#(
   parameter int          IRQ_W      = 8,
   parameter int          EXC_W      = 5,
   parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
   input  logic             clk,
   input  logic             res,
   exception_unit_if.slave  io_exc
);

   exc_state_e       r_state;
   exc_state_e       w_state_next;
   logic             w_accept;
   logic             w_commit_load;

   logic [IRQ_W-1:0] r_pend;
   logic [IRQ_W-1:0] w_masked;
   logic             w_int_en;

   logic             w_enc_valid;
   exc_kind_e        w_enc_kind;
   logic [EXC_W-1:0] w_enc_code;

   exc_kind_e        r_kind;
   logic [EXC_W-1:0] r_code;
   logic [31:0]      r_epc;
   logic [31:0]      r_bad_vaddr;

   logic             w_is_exc;
   logic [7:0]       w_ip8;
   logic [31:0]      w_cause_new;

   logic             r_redirect;
   logic             r_we_status;
   logic             r_we_cause;
   logic             r_we_epc;
   logic             r_we_badvaddr;
   logic [31:0]      r_redirect_pc;
   logic [31:0]      r_out_status;
   logic [31:0]      r_out_cause;
   logic [31:0]      r_out_epc;
   logic [31:0]      r_out_badvaddr;

   logic             w_unused;

   assign w_masked = r_pend & io_exc.cp0_status[STATUS_IM_LSB +: IRQ_W];
   assign w_int_en = io_exc.cp0_status[STATUS_IE_BIT] & ~io_exc.cp0_status[STATUS_EXL_BIT];
   assign w_unused = ^io_exc.cp0_cause[15:0];

   exc_prio_enc #(
      .IRQ_W (IRQ_W),
      .EXC_W (EXC_W)
   ) u_prio_enc (
      .i_masked        (w_masked),
      .i_int_en        (w_int_en),
      .i_mmu_exception (io_exc.mmu_exception),
      .i_syscall       (io_exc.syscall),
      .i_eret          (io_exc.eret),
      .o_valid         (w_enc_valid),
      .o_kind          (w_enc_kind),
      .o_code          (w_enc_code)
   );

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Events are only looked at in IDLE; the stalled pipeline re-presents them later.
   always_comb begin
      w_state_next  = r_state;
      w_accept      = 1'b0;
      w_commit_load = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_enc_valid) begin
               w_accept     = 1'b1;
               w_state_next = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (io_exc.flush_ack) begin
               w_commit_load = 1'b1;
               w_state_next  = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_kind      <= KIND_INT;
         r_code      <= '0;
         r_epc       <= '0;
         r_bad_vaddr <= '0;
      end else if (w_accept) begin
         r_kind      <= w_enc_kind;
         r_code      <= w_enc_code;
         r_bad_vaddr <= io_exc.bad_vaddr;
         r_epc       <= (w_enc_kind == KIND_SYS) ? (io_exc.pc + 32'd4) : io_exc.pc;
      end
   end

   assign w_is_exc = (r_kind != KIND_ERET);
   assign w_ip8    = 8'(w_masked);

   always_comb begin
      w_cause_new                             = {io_exc.cp0_cause[31:16], w_ip8, 8'h00};
      w_cause_new[CAUSE_EXC_LSB +: EXC_W]     = r_code;
   end

   // Commit data is captured as FLUSH ends so every COMMIT output is a flop.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_redirect     <= 1'b0;
         r_we_status    <= 1'b0;
         r_we_cause     <= 1'b0;
         r_we_epc       <= 1'b0;
         r_we_badvaddr  <= 1'b0;
         r_redirect_pc  <= '0;
         r_out_status   <= '0;
         r_out_cause    <= '0;
         r_out_epc      <= '0;
         r_out_badvaddr <= '0;
      end else begin
         r_redirect    <= w_commit_load;
         r_we_status   <= w_commit_load;
         r_we_cause    <= w_commit_load & w_is_exc;
         r_we_epc      <= w_commit_load & w_is_exc & ~io_exc.cp0_status[STATUS_EXL_BIT];
         r_we_badvaddr <= w_commit_load & (r_kind == KIND_MMU);
         if (w_commit_load) begin
            r_out_status   <= status_with_exl(io_exc.cp0_status, w_is_exc);
            r_out_cause    <= w_cause_new;
            r_out_epc      <= r_epc;
            r_out_badvaddr <= r_bad_vaddr;
            r_redirect_pc  <= w_is_exc ? EXC_VECTOR : io_exc.cp0_epc;
         end
      end
   end

`ifdef EXCEPTION_UNIT_IRQ_EDGE_EN
   logic [IRQ_W-1:0] r_irq_q;
   logic [IRQ_W-1:0] w_pend_clr;

   // Only the bits reported in the committed Cause are retired; a new edge wins.
   assign w_pend_clr = ((r_state == ST_COMMIT) && (r_kind == KIND_INT))
                       ? r_out_cause[CAUSE_IP_LSB +: IRQ_W] : '0;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_irq_q <= '0;
      end else begin
         r_irq_q <= io_exc.irq;
      end
   end

   for (genvar gi = 0; gi < IRQ_W; gi++) begin : g_pend
      always_ff @(posedge clk or negedge res) begin
         if (!res) begin
            r_pend[gi] <= 1'b0;
         end else begin
            r_pend[gi] <= (r_pend[gi] & ~w_pend_clr[gi]) | (io_exc.irq[gi] & ~r_irq_q[gi]);
         end
      end
   end
`else
   for (genvar gi = 0; gi < IRQ_W; gi++) begin : g_pend
      always_ff @(posedge clk or negedge res) begin
         if (!res) begin
            r_pend[gi] <= 1'b0;
         end else begin
            r_pend[gi] <= io_exc.irq[gi];
         end
      end
   end
`endif

   assign io_exc.flush_req    = (r_state == ST_FLUSH);
   assign io_exc.busy         = (r_state != ST_IDLE);
   assign io_exc.redirect     = r_redirect;
   assign io_exc.redirect_pc  = r_redirect_pc;
   assign io_exc.we_status    = r_we_status;
   assign io_exc.we_cause     = r_we_cause;
   assign io_exc.we_epc       = r_we_epc;
   assign io_exc.we_badVAddr  = r_we_badvaddr;
   assign io_exc.out_status   = r_out_status;
   assign io_exc.out_cause    = r_out_cause;
   assign io_exc.out_epc      = r_out_epc;
   assign io_exc.out_badVAddr = r_out_badvaddr;

endmodule

// File: tb/tb_exception_unit.sv
// Self-checking bench for exception_unit: directed cases plus randomized
// transactions against a transaction-level reference model.
module tb_exception_unit;
   import exception_unit_pkg::*;

   logic clk;
   logic res;
   int   n_total;
   int   n_bad;
   int   n_txn;

   exception_unit_if #(.IRQ_W(8), .EXC_W(5)) ifc ();

   exception_unit #(
      .IRQ_W      (8),
      .EXC_W      (5),
      .EXC_VECTOR (32'h8000_0180)
   ) dut (
      .clk    (clk),
      .res    (res),
      .io_exc (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          valid;
      int          kind;
      logic [31:0] status;
      logic [31:0] cause;
      logic [31:0] epc;
      logic [31:0] badv;
      logic [31:0] rpc;
      bit          we_cause;
      bit          we_epc;
      bit          we_badv;
   } exp_t;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // kind: 0=interrupt 1=mmu 2=syscall 3=eret
   function automatic exp_t model(input logic [7:0] irq_v, input logic [31:0] st,
                                  input logic [31:0] ca, input logic [31:0] ep,
                                  input logic [31:0] pc_v, input logic [31:0] bv,
                                  input logic [4:0] mmu_v, input logic sys_v,
                                  input logic eret_v);
      exp_t       e;
      logic [7:0] masked;
      logic [4:0] code;
      e        = '{default: 0};
      masked   = irq_v & st[15:8];
      code     = 5'd0;
      e.valid  = 1'b1;
      if (st[0] && !st[1] && masked != 8'h00) begin
         e.kind = 0;
      end else if (mmu_v != 5'd0) begin
         e.kind = 1;
         code   = mmu_v;
      end else if (sys_v) begin
         e.kind = 2;
         code   = 5'd8;
      end else if (eret_v) begin
         e.kind = 3;
      end else begin
         e.valid = 1'b0;
      end
      if (e.kind == 3) begin
         e.status = st & ~32'h2;
         e.rpc    = ep;
      end else begin
         e.status   = st | 32'h2;
         e.rpc      = 32'h8000_0180;
         e.we_cause = 1'b1;
         e.we_epc   = !st[1];
         e.we_badv  = (e.kind == 1);
         e.cause    = {ca[31:16], masked, 1'b0, code, 2'b00};
         e.epc      = (e.kind == 2) ? pc_v + 32'd4 : pc_v;
         e.badv     = bv;
      end
      return e;
   endfunction

   task automatic clear_inputs();
      ifc.mmu_exception = '0;
      ifc.syscall       = 1'b0;
      ifc.eret          = 1'b0;
      ifc.irq           = '0;
      ifc.pc            = '0;
      ifc.bad_vaddr     = '0;
      ifc.cp0_status    = '0;
      ifc.cp0_cause     = '0;
      ifc.cp0_epc       = '0;
      ifc.flush_ack     = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_flush_req"}, 32'(ifc.flush_req), 32'd0);
      check_val({tag, "_busy"}, 32'(ifc.busy), 32'd0);
      check_val({tag, "_redirect"}, 32'(ifc.redirect), 32'd0);
      check_val({tag, "_strobes"}, 32'({ifc.we_status, ifc.we_cause, ifc.we_epc, ifc.we_badVAddr}), 32'd0);
      check_val({tag, "_redirect_pc"}, ifc.redirect_pc, 32'd0);
      check_val({tag, "_out_status"}, ifc.out_status, 32'd0);
      check_val({tag, "_out_cause"}, ifc.out_cause, 32'd0);
      check_val({tag, "_out_epc"}, ifc.out_epc, 32'd0);
      check_val({tag, "_out_badv"}, ifc.out_badVAddr, 32'd0);
   endtask

   // dly < 0: flush_ack tied high; otherwise flush_req is held max(dly,1) cycles.
   task automatic run_case(input string tag, input logic [7:0] irq_v, input logic [31:0] st,
                           input logic [31:0] ca, input logic [31:0] ep,
                           input logic [31:0] pc_v, input logic [31:0] bv,
                           input logic [4:0] mmu_v, input logic sys_v,
                           input logic eret_v, input int dly);
      exp_t e;
      e = model(irq_v, st, ca, ep, pc_v, bv, mmu_v, sys_v, eret_v);
      n_txn++;
      $display("txn %0d %s kind=%0d valid=%0d ack_dly=%0d", n_txn, tag, e.kind, e.valid, dly);
      ifc.irq        = irq_v;
      ifc.cp0_status = st;
      ifc.cp0_cause  = ca;
      ifc.cp0_epc    = ep;
      ifc.flush_ack  = (dly < 0);
      @(negedge clk);
      ifc.pc            = pc_v;
      ifc.bad_vaddr     = bv;
      ifc.mmu_exception = mmu_v;
      ifc.syscall       = sys_v;
      ifc.eret          = eret_v;
      @(negedge clk);
      if (!e.valid) begin
         check_val({tag, "_noevent_busy"}, 32'(ifc.busy), 32'd0);
         clear_inputs();
         @(negedge clk);
         return;
      end
      check_val({tag, "_flush_req"}, 32'(ifc.flush_req), 32'd1);
      check_val({tag, "_flush_redirect"}, 32'(ifc.redirect), 32'd0);
      ifc.mmu_exception = '0;
      ifc.syscall       = 1'b0;
      ifc.eret          = 1'b0;
      if (dly <= 1) ifc.flush_ack = 1'b1;
      for (int d = 2; d <= dly; d++) begin
         @(negedge clk);
         check_val({tag, "_flush_held"}, 32'(ifc.flush_req), 32'd1);
         check_val({tag, "_flush_no_strobe"}, 32'(ifc.we_status), 32'd0);
         if (d == dly) ifc.flush_ack = 1'b1;
      end
      @(negedge clk);
      check_val({tag, "_commit_redirect"}, 32'(ifc.redirect), 32'd1);
      check_val({tag, "_commit_flush_req"}, 32'(ifc.flush_req), 32'd0);
      check_val({tag, "_commit_busy"}, 32'(ifc.busy), 32'd1);
      check_val({tag, "_we_status"}, 32'(ifc.we_status), 32'd1);
      check_val({tag, "_we_cause"}, 32'(ifc.we_cause), 32'(e.we_cause));
      check_val({tag, "_we_epc"}, 32'(ifc.we_epc), 32'(e.we_epc));
      check_val({tag, "_we_badv"}, 32'(ifc.we_badVAddr), 32'(e.we_badv));
      check_val({tag, "_out_status"}, ifc.out_status, e.status);
      check_val({tag, "_redirect_pc"}, ifc.redirect_pc, e.rpc);
      if (e.kind != 3) begin
         check_val({tag, "_out_cause"}, ifc.out_cause, e.cause);
         check_val({tag, "_out_epc"}, ifc.out_epc, e.epc);
      end
      if (e.kind == 1) check_val({tag, "_out_badv"}, ifc.out_badVAddr, e.badv);
      clear_inputs();
      @(negedge clk);
      check_val({tag, "_post_busy"}, 32'(ifc.busy), 32'd0);
      check_val({tag, "_post_redirect"}, 32'(ifc.redirect), 32'd0);
      check_val({tag, "_post_we_status"}, 32'(ifc.we_status), 32'd0);
      @(negedge clk);
      check_val({tag, "_idle_busy"}, 32'(ifc.busy), 32'd0);
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      n_txn   = 0;
      res     = 1'b0;
      clear_inputs();
      #2;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      res = 1'b1;
      @(negedge clk);

      run_case("int_level", 8'h04, 32'h0000_0401, 32'h0000_0000, 32'h0, 32'h100, 32'h0,
               5'd0, 1'b0, 1'b0, -1);
      run_case("mmu_tlbl", 8'h00, 32'h0000_0000, 32'h0000_0000, 32'h0, 32'h400, 32'h1234,
               5'(CPU_EXCEPTION_TLBL), 1'b0, 1'b0, 3);
      run_case("sys_exl", 8'h00, 32'h0000_0002, 32'hABCD_0000, 32'h0, 32'h500, 32'h0,
               5'd0, 1'b1, 1'b0, 0);

      // Simultaneous INT, MMU and syscall; MMU taken in the first IDLE cycle after COMMIT.
      n_txn++;
      $display("txn %0d b2b int_then_mmu", n_txn);
      ifc.irq        = 8'h04;
      ifc.cp0_status = 32'h0000_0401;
      ifc.flush_ack  = 1'b1;
      @(negedge clk);
      ifc.mmu_exception = 5'(CPU_EXCEPTION_TLBL);
      ifc.syscall       = 1'b1;
      ifc.pc            = 32'h600;
      ifc.bad_vaddr     = 32'hABC;
      @(negedge clk);
      check_val("b2b_flush1", 32'(ifc.flush_req), 32'd1);
      @(negedge clk);
      check_val("b2b_int_code", 32'(ifc.out_cause[6:2]), 32'd0);
      check_val("b2b_int_ip", 32'(ifc.out_cause[15:8]), 32'h04);
      ifc.cp0_status = 32'h0000_0403;
      @(negedge clk);
      check_val("b2b_idle_gap", 32'(ifc.busy), 32'd0);
      @(negedge clk);
      check_val("b2b_flush2", 32'(ifc.flush_req), 32'd1);
      @(negedge clk);
      check_val("b2b_mmu_code", 32'(ifc.out_cause[6:2]), 32'(CPU_EXCEPTION_TLBL));
      check_val("b2b_mmu_we_epc", 32'(ifc.we_epc), 32'd0);
      check_val("b2b_mmu_we_badv", 32'(ifc.we_badVAddr), 32'd1);
      check_val("b2b_mmu_badv", ifc.out_badVAddr, 32'hABC);
      check_val("b2b_mmu_epc", ifc.out_epc, 32'h600);
      clear_inputs();
      @(negedge clk);
      check_val("b2b_end_busy", 32'(ifc.busy), 32'd0);
      @(negedge clk);

      run_case("mmu_wins_ie0", 8'h04, 32'h0000_0400, 32'h0, 32'h0, 32'h700, 32'h55,
               5'(CPU_EXCEPTION_TLBS), 1'b1, 1'b0, 1);
      run_case("eret", 8'h00, 32'h0000_FF03, 32'h0, 32'h800, 32'h0, 32'h0,
               5'd0, 1'b0, 1'b1, 0);

      // Reset asserted in the middle of FLUSH.
      n_txn++;
      $display("txn %0d reset_mid_flush", n_txn);
      ifc.mmu_exception = 5'(CPU_EXCEPTION_TLBS);
      ifc.pc            = 32'h900;
      @(negedge clk);
      check_val("rstflush_flush_req", 32'(ifc.flush_req), 32'd1);
      ifc.mmu_exception = '0;
      @(negedge clk);
      check_val("rstflush_held", 32'(ifc.flush_req), 32'd1);
      res = 1'b0;
      #1;
      check_all_zero("rstflush");
      @(negedge clk);
      res = 1'b1;
      @(negedge clk);
      check_val("rstflush_after_busy", 32'(ifc.busy), 32'd0);

`ifdef EXCEPTION_UNIT_IRQ_EDGE_EN
      n_txn++;
      $display("txn %0d edge_irq_pending_through_exl", n_txn);
      ifc.cp0_status = 32'h0000_0403;
      ifc.irq        = 8'h04;
      @(negedge clk);
      ifc.irq = 8'h00;
      repeat (3) @(negedge clk);
      check_val("edge_exl_blocks", 32'(ifc.busy), 32'd0);
      ifc.cp0_epc   = 32'h900;
      ifc.eret      = 1'b1;
      ifc.flush_ack = 1'b1;
      @(negedge clk);
      check_val("edge_eret_flush", 32'(ifc.flush_req), 32'd1);
      ifc.eret = 1'b0;
      @(negedge clk);
      check_val("edge_eret_rpc", ifc.redirect_pc, 32'h900);
      check_val("edge_eret_status", ifc.out_status, 32'h0000_0401);
      ifc.cp0_status = 32'h0000_0401;
      @(negedge clk);
      check_val("edge_gap_busy", 32'(ifc.busy), 32'd0);
      @(negedge clk);
      check_val("edge_int_flush", 32'(ifc.flush_req), 32'd1);
      @(negedge clk);
      check_val("edge_int_ip", 32'(ifc.out_cause[15:8]), 32'h04);
      check_val("edge_int_code", 32'(ifc.out_cause[6:2]), 32'd0);
      @(negedge clk);
      @(negedge clk);
      check_val("edge_pend_cleared", 32'(ifc.busy), 32'd0);
      clear_inputs();
      @(negedge clk);
`endif

      for (int i = 0; i < 40; i++) begin
         logic [7:0]  r_irq;
         logic [31:0] r_st;
         logic [4:0]  r_mmu;
         int          r_dly;
`ifdef EXCEPTION_UNIT_IRQ_EDGE_EN
         r_irq = 8'h00;
`else
         r_irq = 8'($urandom);
`endif
         r_st  = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
         r_mmu = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         r_dly = $urandom_range(0, 4) - 1;
         run_case($sformatf("rnd%0d", i), r_irq, r_st, $urandom, $urandom,
                  {$urandom, 2'b00}, $urandom, r_mmu, 1'($urandom), 1'($urandom), r_dly);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/exception_unit.md
# exception_unit

Parametrised, sequential successor to the combinational exception controller, placed between the execute/memory stage and CP0. It latches interrupt requests and prioritises interrupt, MMU and syscall exceptions plus ERET. It drains the pipeline through a flush handshake, then commits CP0 updates and a PC redirect in a single cycle. IRQ width, exception-code width and vector address are generalised; the edge-triggered IRQ capture mode is optional.

## Interface
- IRQ_W, 8, number of interrupt lines (1..8), mapped LSB-first onto Cause[15:8], unused bits zero
- EXC_W, 5, exception code width, placed at Cause[2+EXC_W-1:2]
- EXC_VECTOR, 32'h8000_0180, redirect target on exception entry
- clk  in  1  single clock, rising edge
- res  in  1  reset, asynchronous, active-low
- mmu_exception  in  EXC_W  MMU exception code, MMU_EXC_NONE = no fault
- syscall  in  1  syscall in commit stage
- eret  in  1  ERET in commit stage
- irq  in  IRQ_W  raw interrupt lines
- pc  in  32  PC of the commit-stage instruction
- bad_vaddr  in  32  faulting address from the MMU
- cp0_status, cp0_cause, cp0_epc  in  32 each  current CP0 values
- flush_ack  in  1  pipeline drained
- flush_req  out  1  request pipeline drain
- busy  out  1  FSM not IDLE
- redirect  out  1  one-cycle PC redirect strobe
- redirect_pc  out  32  redirect target
- we_status, we_cause, we_epc, we_badVAddr  out  1 each  CP0 write strobes
- out_status, out_cause, out_epc, out_badVAddr  out  32 each  CP0 write data

## Operation
- Status fields: IE = bit0, EXL = bit1, IM = bits[15:8].
- Pending register `pend[IRQ_W-1:0]`. Level mode: pend <= irq every cycle.
- Masked IRQ: pend & IM[IRQ_W-1:0].
- Priority, evaluated in IDLE only, highest first:
  1. INT: IE && !EXL && |masked, code CPU_EXCEPTION_INT.
  2. MMU: mmu_exception != NONE.
  3. SYS: syscall.
  4. ERET: eret.
- FSM states: IDLE, FLUSH, COMMIT.
- IDLE:
  - Any event: latch kind, code and bad_vaddr. Latch epc_r = pc + 4 for SYS, otherwise pc. Go to FLUSH.
  - No event: stay in IDLE.
- FLUSH: flush_req = 1 until flush_ack is sampled high, then go to COMMIT. flush_ack in the same cycle as entry is honoured on the next edge.
- COMMIT: one cycle, then return to IDLE.
  - Exception kinds:
    - we_status = we_cause = 1.
    - we_epc = !EXL.
    - we_badVAddr only for MMU.
    - out_status = cp0_status with EXL = 1.
    - out_cause = {cp0_cause[31:16], masked zero-padded to 8, 1'b0, code, 2'b00}.
    - redirect_pc = EXC_VECTOR.
  - ERET:
    - we_status = 1 only; out_status = cp0_status with EXL = 0.
    - redirect_pc = cp0_epc.
  - redirect = 1 in both cases.
- Events arriving in FLUSH or COMMIT are ignored. The pipeline is stalled, and the source re-presents the event after restart.
- pend keeps sampling in every state.
- Reset, asynchronous, at any point including mid-FLUSH: state = IDLE and pend = 0. All outputs, including out_* data, go to 0.

## Timing
- Every output is registered or decoded from state. No combinational path from inputs to flush_req or the strobes.
- Event sampled at edge N: flush_req high after N.
- flush_ack high at edge M: COMMIT strobes high for exactly the cycle after M, then IDLE.
- Minimum entry-to-redirect latency is 2 cycles (flush_ack already high).
- Back-to-back: a new event is accepted in the first IDLE cycle after COMMIT.
- CP0 writes land at the COMMIT edge. cp0_* inputs reflect the new values from the following cycle.

## Configuration
- EXCEPTION_UNIT_IRQ_EDGE_EN.
- Defined:
  - pend |= irq & ~irq_q, where irq_q is a registered copy of irq.
  - Bits are cleared by COMMIT of an INT, clearing exactly the masked bits reported in out_cause.
  - An edge that coincides with the clear is kept.
- Undefined: level mode, as in Operation; irq_q is not instantiated.

## Structure
- The shared CPU package holds MMU_EXC_NONE, the CPU_EXCEPTION_* codes (INT, SYS), the Status bit indices and the default EXC_VECTOR, so the MMU and the CP0 use the same definitions.
- One sub-module, exc_prio_enc: combinational priority encoder taking masked IRQ, mmu_exception, syscall and eret, producing valid, kind and code. The FSM stays in exception_unit.

## Test plan
- Level mode. IE=1, EXL=0, IM=8'h04, irq=8'h04, flush_ack tied high: flush_req the next cycle, COMMIT one cycle later. out_cause[15:8]=8'h04, code=INT, we_epc=1, redirect_pc=8000_0180.
- mmu_exception=TLBL, pc=0x400, bad_vaddr=0x1234, flush_ack delayed 3 cycles: flush_req held 3 cycles. Then out_epc=0x400, we_badVAddr=1, out_badVAddr=0x1234, out_status EXL=1.
- syscall at pc=0x500 with EXL=1: out_epc=0x504 but we_epc=0; code=SYS.
- Simultaneous masked IRQ, MMU fault and syscall with IE=1: INT wins, then MMU is taken in the first IDLE cycle after it is re-presented. With IE=0, MMU wins.
- eret with cp0_epc=0x800: we_status only, EXL cleared, redirect_pc=0x800. Reset asserted mid-FLUSH: all outputs 0 immediately and state IDLE.
- With EXCEPTION_UNIT_IRQ_EDGE_EN: a 1-cycle irq pulse while EXL=1 stays pending and is taken after ERET clears EXL. The bit is cleared at COMMIT.
